// File: rtl/x_seq_driver.sv
// Serial stimulus source for the 3-bit JK state machine.
// Shifts a latched pattern out on x (LSB first, one bit per clock), samples
// the machine's F result on f_in and counts the cycles it was high.
// LEN must be 1..16 and 2**IDX_W must be >= LEN.
module x_seq_driver #(
    parameter int unsigned LEN   = 8,
    parameter int unsigned IDX_W = 4,
    parameter int unsigned CNT_W = 4
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             start,
    input  logic [LEN-1:0]   pattern,
    input  logic             f_in,
    output logic             x,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] hits
);

    typedef enum logic [1:0] {
        StIdle,
        StSend,
        StDrain,
        StDone
    } state_e;

    localparam logic [IDX_W-1:0] LastIdx = IDX_W'(LEN - 1);
    localparam logic [CNT_W-1:0] HitsMax = '1;

    state_e           r_state;
    logic [LEN-1:0]   r_shift;
    logic [IDX_W-1:0] r_idx;
    logic             r_x;
    logic             r_busy;
    logic             r_done;
    logic [CNT_W-1:0] r_hits;
    logic             w_sample;

    // f_in reflects one consumed bit from the second SEND cycle onwards;
    // the DRAIN cycle carries the result of the last bit.
    always_comb begin
        w_sample = ((r_state == StSend) && (r_idx != '0)) || (r_state == StDrain);
    end

    // Run sequencer: shifting, hit counting and all registered outputs.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_state <= StIdle;
            r_shift <= '0;
            r_idx   <= '0;
            r_x     <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_hits  <= '0;
        end else begin
            if (w_sample && f_in && (r_hits != HitsMax)) begin
                r_hits <= r_hits + 1'b1;
            end

            unique case (r_state)
                StIdle: begin
                    r_x    <= 1'b0;
                    r_busy <= 1'b0;
                    r_done <= 1'b0;
                    if (start) begin
                        // Bit 0 goes straight to x; the rest wait in the shifter.
                        r_x     <= pattern[0];
                        r_shift <= pattern >> 1;
                        r_idx   <= '0;
                        r_hits  <= '0;
                        r_busy  <= 1'b1;
                        r_state <= StSend;
                    end
                end
                StSend: begin
                    if (r_idx == LastIdx) begin
                        r_x     <= 1'b0;
                        r_state <= StDrain;
                    end else begin
                        r_x     <= r_shift[0];
                        r_shift <= r_shift >> 1;
                        r_idx   <= r_idx + 1'b1;
                    end
                end
                StDrain: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                    r_state <= StDone;
                end
                StDone: begin
                    r_done  <= 1'b0;
                    r_state <= StIdle;
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

    assign x    = r_x;
    assign busy = r_busy;
    assign done = r_done;
    assign hits = r_hits;

endmodule

// File: tb/tb_x_seq_driver.sv
// Bench for x_seq_driver: randomized and directed runs on an 8-bit instance
// checked by a queue-based scoreboard, plus saturation (LEN=16, CNT_W=3)
// and single-bit (LEN=1) instances.
module tb_x_seq_driver;

    localparam int unsigned LEN   = 8;
    localparam int unsigned CNT_W = 4;

    logic             CLK = 1'b0;
    logic             RESET = 1'b1;
    logic             start = 1'b0;
    logic [LEN-1:0]   pattern = '0;
    logic             f_in = 1'b0;
    logic             x;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] hits;

    always #5 CLK = ~CLK;

    x_seq_driver #(.LEN(LEN), .IDX_W(4), .CNT_W(CNT_W)) dut (
        .CLK(CLK), .RESET(RESET), .start(start), .pattern(pattern), .f_in(f_in),
        .x(x), .busy(busy), .done(done), .hits(hits)
    );

    // Saturation instance: f_in tied high.
    logic        b_start = 1'b0;
    logic [15:0] b_pat = 16'hC35A;
    logic        b_x, b_busy, b_done;
    logic [2:0]  b_hits;

    x_seq_driver #(.LEN(16), .IDX_W(4), .CNT_W(3)) dut_sat (
        .CLK(CLK), .RESET(RESET), .start(b_start), .pattern(b_pat), .f_in(1'b1),
        .x(b_x), .busy(b_busy), .done(b_done), .hits(b_hits)
    );

    // Single-bit instance.
    logic       c_start = 1'b0;
    logic [0:0] c_pat = 1'b1;
    logic       c_x, c_busy, c_done;
    logic [1:0] c_hits;

    x_seq_driver #(.LEN(1), .IDX_W(1), .CNT_W(2)) dut_one (
        .CLK(CLK), .RESET(RESET), .start(c_start), .pattern(c_pat), .f_in(1'b1),
        .x(c_x), .busy(c_busy), .done(c_done), .hits(c_hits)
    );

    typedef struct {
        logic [LEN-1:0] pat;
        logic [LEN:0]   fv;   // f_in driven during cycles 0..LEN of the run
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Hits visible during run cycle k: high f_in cycles 1..k-1, saturated.
    function automatic int model_hits(input logic [LEN:0] fv, input int k, input int cw);
        int s = 0;
        int mx = (1 << cw) - 1;
        for (int j = 1; j < k; j++) s += int'(fv[j]);
        return (s > mx) ? mx : s;
    endfunction

    // Monitor: pops an expectation when a run appears and checks every cycle.
    int   cyc = 0;
    int   k_run = -1;
    exp_t cur;
    int   last_hits = 0;
    int   prev_start = -100;
    int   last_start = -100;
    logic mon_en = 1'b0;

    always @(negedge CLK) begin
        cyc++;
        if (!RESET) begin
            k_run = -1;
            last_hits = 0;
            sb.delete();
        end else if (mon_en) begin
            if (k_run < 0 && busy) begin
                if (sb.size() == 0) begin
                    chk("unexpected_run_busy", int'(busy), 0);
                end else begin
                    cur = sb.pop_front();
                    k_run = 0;
                    prev_start = last_start;
                    last_start = cyc;
                end
            end
            if (k_run >= 0) begin
                chk("run_x", int'(x), (k_run < LEN) ? int'(cur.pat[k_run]) : 0);
                chk("run_busy", int'(busy), (k_run <= LEN) ? 1 : 0);
                chk("run_done", int'(done), (k_run == LEN + 1) ? 1 : 0);
                chk("run_hits", int'(hits), model_hits(cur.fv, k_run, CNT_W));
                if (k_run == LEN + 1) begin
                    last_hits = model_hits(cur.fv, k_run, CNT_W);
                    k_run = -1;
                end else begin
                    k_run++;
                end
            end else begin
                chk("idle_x", int'(x), 0);
                chk("idle_done", int'(done), 0);
                chk("idle_hits", int'(hits), last_hits);
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        @(negedge CLK);
        while ((busy || done) && n < 100) begin
            @(negedge CLK);
            n++;
        end
        if (n >= 100) chk("idle_timeout", int'(busy | done), 0);
    endtask

    // One run; poke >= 0 pulses start and scrambles pattern in that cycle.
    task automatic run(input logic [LEN-1:0] p, input logic [LEN:0] fv, input int poke);
        wait_idle();
        pattern = p;
        start = 1'b1;
        sb.push_back('{pat: p, fv: fv});
        @(posedge CLK);
        #1 start = 1'b0;
        f_in = fv[0];
        for (int k = 1; k <= LEN; k++) begin
            @(posedge CLK);
            #1 f_in = fv[k];
            start = 1'b0;
            if (k == poke) begin
                start = 1'b1;
                pattern = ~p;
            end
        end
        @(posedge CLK);
        #1 f_in = 1'b0;
        start = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        logic [LEN-1:0] p;
        logic [LEN:0]   fv;
        int             poke;

        #1 RESET = 1'b0;
        #2;
        chk("reset_x", int'(x), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);
        chk("reset_hits", int'(hits), 0);
        @(posedge CLK);
        #2 RESET = 1'b1;
        mon_en = 1'b1;

        run(8'hA6, '0, -1);
        run(8'hFF, '1, -1);
        repeat (5) @(posedge CLK);
        run(8'h3C, 9'b1_0000_0001, -1);
        run(8'h5A, 9'(($urandom)), 3);

        // Start held high: back-to-back runs one IDLE cycle apart.
        wait_idle();
        pattern = 8'h81;
        f_in = 1'b0;
        start = 1'b1;
        sb.push_back('{pat: 8'h81, fv: '0});
        sb.push_back('{pat: 8'h7E, fv: '0});
        @(posedge CLK);
        #1 pattern = 8'h7E;
        repeat (LEN + 3) @(posedge CLK);
        #1 start = 1'b0;
        wait_idle();
        chk("b2b_gap", last_start - prev_start, LEN + 3);

        // Asynchronous reset mid-SEND.
        wait_idle();
        pattern = 8'hFF;
        start = 1'b1;
        sb.push_back('{pat: 8'hFF, fv: '1});
        @(posedge CLK);
        #1 start = 1'b0;
        f_in = 1'b1;
        repeat (3) @(posedge CLK);
        #2 RESET = 1'b0;
        #1;
        chk("async_rst_x", int'(x), 0);
        chk("async_rst_busy", int'(busy), 0);
        chk("async_rst_done", int'(done), 0);
        chk("async_rst_hits", int'(hits), 0);
        f_in = 1'b0;
        @(negedge CLK);
        @(posedge CLK);
        #2 RESET = 1'b1;
        repeat (6) @(posedge CLK);

        for (int r = 0; r < 20; r++) begin
            p = LEN'($urandom);
            fv = 9'($urandom);
            poke = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, LEN - 1)) : -1;
            repeat ($urandom_range(0, 3)) @(posedge CLK);
            run(p, fv, poke);
        end
        wait_idle();

        // Saturation instance.
        @(negedge CLK);
        b_start = 1'b1;
        @(posedge CLK);
        #1 b_start = 1'b0;
        for (int k = 0; k <= 18; k++) begin
            @(negedge CLK);
            chk("sat_x", int'(b_x), (k < 16) ? int'(b_pat[k]) : 0);
            chk("sat_done", int'(b_done), (k == 17) ? 1 : 0);
            chk("sat_hits", int'(b_hits), (k < 2) ? 0 : ((k - 1 > 7) ? 7 : k - 1));
        end

        // LEN=1 instance.
        @(negedge CLK);
        c_start = 1'b1;
        @(posedge CLK);
        #1 c_start = 1'b0;
        for (int k = 0; k <= 3; k++) begin
            @(negedge CLK);
            chk("one_x", int'(c_x), (k == 0) ? 1 : 0);
            chk("one_busy", int'(c_busy), (k <= 1) ? 1 : 0);
            chk("one_done", int'(c_done), (k == 2) ? 1 : 0);
            chk("one_hits", int'(c_hits), (k >= 2) ? 1 : 0);
        end

        repeat (2) @(posedge CLK);
        chk("scoreboard_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/x_seq_driver.md
Name: x_seq_driver

Overview:
- Serial stimulus source for the 3-bit JK state machine: shifts a parallel pattern out on single-bit `x`, LSB first, one bit per clock.
- Samples the machine's `F` output back on `f_in` and counts hit cycles over the run.
- Sits beside the state machine in the PA test harness. It is the writer of the `x` stream the machine reads, and the reader of its `F` result.

Parameters:
- LEN, 8, pattern length in bits; legal range 1..16.
- IDX_W, 4, width of the internal bit index; must satisfy 2^IDX_W >= LEN.
- CNT_W, 4, width of the `hits` counter.

Ports:
- CLK  in  1  system clock; all state changes on the rising edge.
- RESET  in  1  asynchronous, active-low reset.
- start  in  1  request to begin a run; sampled only in IDLE.
- pattern  in  LEN  bits to send; `pattern[0]` goes first; latched on accepted start.
- f_in  in  1  `F` output of the driven state machine.
- x  out  1  serial bit to the machine; registered.
- busy  out  1  high while a run is in progress.
- done  out  1  one-cycle pulse at the end of a run.
- hits  out  CNT_W  number of cycles `f_in` was high during the run; saturating.

Behaviour:
- Reset (RESET=0, asynchronous): state=IDLE, x=0, busy=0, done=0, hits=0, index=0, shift register=0. Takes effect immediately, including mid-run. The run is abandoned and no done pulse is issued.
- States: IDLE, SEND, DRAIN, DONE. All outputs are registered.
- IDLE:
  - x=0, busy=0, done=0; hits holds the last run's result.
  - On start=1 at edge e0: latch pattern, set x<=pattern[0], index<=0, hits<=0, busy<=1, go to SEND.
- SEND:
  - Bit k is presented on x for exactly one cycle. The machine consumes it at the next edge.
  - At each edge, if index < LEN-1: x<=next bit, index++.
  - If index == LEN-1: x<=0, go to DRAIN.
- Hit sampling:
  - At every edge where state is SEND with index >= 1, or state is DRAIN, sample f_in; if f_in=1, hits++.
  - Each sampled f_in value reflects the machine state after one consumed bit.
  - Exactly LEN samples are taken per run.
  - The SEND cycle with index=0 is not sampled, because f_in still reflects the pre-run state.
- Saturation: hits saturates at 2^CNT_W-1 and never wraps.
- DRAIN: one cycle; takes the final sample, then goes to DONE with busy<=0 and done<=1.
- DONE: one cycle with done=1; go to IDLE with done<=0.
- Timing summary: with start accepted at edge e0, x carries pattern bit k during cycle k (k=0..LEN-1), done is high in cycle LEN+1, and the block is back in IDLE at cycle LEN+2.
- start handling:
  - start is ignored in SEND, DRAIN and DONE; no queuing.
  - start held high continuously causes back-to-back runs with one IDLE cycle between them.
- pattern: changes on the pattern input after acceptance have no effect on the current run.
- LEN=1: one SEND cycle, then DRAIN; exactly one hit sample.

Test Plan:
- Reset release, start=1 with pattern=8'hA6 (LEN=8), f_in=0: x over cycles 0..7 = 0,1,1,0,0,1,0,1; x=0 after; busy high for cycles 0..8; done=1 in cycle 9 only; hits=0.
- pattern=8'hFF, f_in tied 1: hits=8 at done; hits still 8 in IDLE until the next accepted start clears it to 0.
- LEN=16, CNT_W=3, f_in tied 1: hits saturates at 7 and does not wrap to 0.
- f_in=1 only in the cycle after start (index=0 cycle) and in the DRAIN cycle: hits=1. This checks that the index-0 cycle is excluded and DRAIN is included.
- Pulse start at cycle 3 of a run, and change pattern mid-run: no restart, x sequence unchanged, single done pulse.
- Assert RESET=0 asynchronously mid-SEND (between clock edges): x, busy, done and hits go to 0 immediately with no clock edge needed; after release, the block sits in IDLE with no done pulse.
